sprite_line_render: RTL and testbench

- Consumer end of the sprite attribute holding stage: takes one loaded sprite slot and serializes it into pixels as the beam sweeps the scanline.
- Slot fields: posX, sclX, swpX, bcolor1..4, colors (16 px × 2 bit).
- Emits a 5-bit palette color and opacity flag per pixel strobe.
- Pulses slot_take so the holding stage can shift in the next sprite's attributes.

---
 rtl/sprite_line_render_if.sv | 24 ++
 rtl/sprite_line_render.sv | 163 ++++++++++++++++
 tb/tb_sprite_line_render.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_render_if.sv
// rtl/sprite_line_render_if.sv - sprite slot handoff between holding stage and line renderer
// The holding stage drives a slot (master); the renderer latches it and pulses slot_take (slave).
interface sprite_line_render_if;
  logic        slot_valid;
  logic [8:0]  pos_x;
  logic [3:0]  scl_x;
  logic        swp_x;
  logic [4:0]  bcolor1;
  logic [4:0]  bcolor2;
  logic [4:0]  bcolor3;
  logic [4:0]  bcolor4;
  logic [31:0] colors;
  logic        slot_take;

  modport master (
    output slot_valid, pos_x, scl_x, swp_x, bcolor1, bcolor2, bcolor3, bcolor4, colors,
    input  slot_take
  );

  modport slave (
    input  slot_valid, pos_x, scl_x, swp_x, bcolor1, bcolor2, bcolor3, bcolor4, colors,
    output slot_take
  );
endinterface

// File: rtl/sprite_line_render.sv
// rtl/sprite_line_render.sv - serializes one latched sprite slot into per-strobe palette pixels
// Optional macro SPRITE_HIT_EN adds bg_opaque_i and a sticky per-line hit_o collision flag.
module sprite_line_render #(
  parameter int LINE_W = 320
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_line_render_if.slave  slot_if,
  input  logic                 line_start_i,
  input  logic                 pix_en_i,
  input  logic [8:0]           hpos_i,
`ifdef SPRITE_HIT_EN
  input  logic                 bg_opaque_i,
  output logic                 hit_o,
`endif
  output logic [4:0]           pix_color_o,
  output logic                 pix_valid_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, ARMED, DRAW, DONE} state_e;

  localparam logic [9:0] LINE_W_C = 10'(LINE_W);

  state_e          state_q, state_d;
  logic [8:0]      pos_x_q;
  logic [3:0]      scl_x_q;
  logic            swp_x_q;
  logic [3:0][4:0] bcolor_q;
  logic [31:0]     colors_q;
  logic [3:0]      s_q, s_d;
  logic [3:0]      r_q, r_d;
  logic [4:0]      pix_color_q, pix_color_d;
  logic            pix_valid_q, pix_valid_d;
  logic            slot_take_q, slot_take_d;
  logic            latch;
  logic            render;
  logic [3:0]      k;
  logic [1:0]      code;
  logic [4:0]      cur_color;
  logic            on_line;

  // Mirroring reads source pixel 15-s, which for a 4-bit index is just ~s.
  assign k         = swp_x_q ? ~s_q : s_q;
  assign code      = colors_q[{k, 1'b0} +: 2];
  assign cur_color = bcolor_q[code];
  assign on_line   = ({1'b0, pos_x_q} < LINE_W_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_x_q     <= '0;
      scl_x_q     <= '0;
      swp_x_q     <= 1'b0;
      bcolor_q    <= '0;
      colors_q    <= '0;
      s_q         <= '0;
      r_q         <= '0;
      pix_color_q <= '0;
      pix_valid_q <= 1'b0;
      slot_take_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      r_q         <= r_d;
      pix_color_q <= pix_color_d;
      pix_valid_q <= pix_valid_d;
      slot_take_q <= slot_take_d;
      if (latch) begin
        pos_x_q  <= slot_if.pos_x;
        scl_x_q  <= slot_if.scl_x;
        swp_x_q  <= slot_if.swp_x;
        bcolor_q <= {slot_if.bcolor4, slot_if.bcolor3, slot_if.bcolor2, slot_if.bcolor1};
        colors_q <= slot_if.colors;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    r_d         = r_q;
    pix_color_d = pix_color_q;
    pix_valid_d = pix_valid_q;
    slot_take_d = 1'b0;
    latch       = 1'b0;
    render      = 1'b0;

    if (line_start_i) begin
      state_d     = IDLE;
      s_d         = '0;
      r_d         = '0;
      pix_color_d = '0;
      pix_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pix_en_i) begin
            pix_color_d = '0;
            pix_valid_d = 1'b0;
          end
          if (slot_if.slot_valid) begin
            latch       = 1'b1;
            slot_take_d = 1'b1;
            s_d         = '0;
            r_d         = '0;
            state_d     = ARMED;
          end
        end
        ARMED: begin
          if (pix_en_i) begin
            if (hpos_i == pos_x_q && on_line) begin
              render  = 1'b1;
              state_d = DRAW;
            end else begin
              pix_color_d = '0;
              pix_valid_d = 1'b0;
            end
          end
        end
        DRAW: render = pix_en_i;
        DONE: begin
          if (pix_en_i) begin
            pix_color_d = '0;
            pix_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A transparent pixel has color 0, so the color register alone is already "0 when not drawing".
    if (render) begin
      pix_color_d = cur_color;
      pix_valid_d = (cur_color != 5'd0);
      if (r_q == scl_x_q) begin
        r_d = '0;
        if (s_q == 4'd15) state_d = DONE;
        else              s_d     = s_q + 4'd1;
      end else begin
        r_d = r_q + 4'd1;
      end
    end
  end

  assign slot_if.slot_take = slot_take_q;
  assign pix_color_o       = pix_color_q;
  assign pix_valid_o       = pix_valid_q;
  assign busy_o            = (state_q == ARMED) || (state_q == DRAW);

`ifdef SPRITE_HIT_EN
  logic hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           hit_q <= 1'b0;
    else if (line_start_i)                                hit_q <= 1'b0;
    else if (render && cur_color != 5'd0 && bg_opaque_i) hit_q <= 1'b1;
  end

  assign hit_o = hit_q;
`endif

endmodule

// File: tb/tb_sprite_line_render.sv
// tb/tb_sprite_line_render.sv - directed table, hand sequences and random model check of sprite_line_render
module tb_sprite_line_render;
  localparam int LINE_W = 320;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  logic       pix_en = 1'b0;
  logic [8:0] hpos = '0;
  logic [4:0] pix_color;
  logic       pix_valid;
  logic       busy;
`ifdef SPRITE_HIT_EN
  logic       bg_opaque = 1'b0;
  logic       hit;
`endif

  sprite_line_render_if sif();

  sprite_line_render #(.LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .slot_if      (sif.slave),
    .line_start_i (line_start),
    .pix_en_i     (pix_en),
    .hpos_i       (hpos),
`ifdef SPRITE_HIT_EN
    .bg_opaque_i  (bg_opaque),
    .hit_o        (hit),
`endif
    .pix_color_o  (pix_color),
    .pix_valid_o  (pix_valid),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [8:0] pos, input logic [3:0] scl, input logic swp,
                      input logic [19:0] bcs, input logic [31:0] col);
    pix_en = 1'b0;
    line_start = 1'b1;
    sif.slot_valid = 1'b0;
    tick();
    line_start = 1'b0;
    sif.pos_x = pos; sif.scl_x = scl; sif.swp_x = swp; sif.colors = col;
    sif.bcolor1 = bcs[4:0]; sif.bcolor2 = bcs[9:5]; sif.bcolor3 = bcs[14:10]; sif.bcolor4 = bcs[19:15];
    sif.slot_valid = 1'b1;
    tick();
    chk("load_take", sif.slot_take, 1);
    // Upstream moves on: the latched sprite must not see these.
    sif.slot_valid = 1'b0;
    sif.pos_x = 9'($urandom); sif.scl_x = 4'($urandom); sif.swp_x = ~swp; sif.colors = $urandom;
    sif.bcolor1 = 5'($urandom); sif.bcolor2 = 5'($urandom);
    tick();
    chk("load_take_drop", sif.slot_take, 0);
  endtask

  task automatic strobe(input int h);
    pix_en = 1'b1;
    hpos = 9'(h);
    tick();
    pix_en = 1'b0;
  endtask

  // Reference model: a loaded sprite counts drawn strobes n; pixel = n/(scale+1).
  typedef struct {
    logic [8:0]      pos;
    logic [3:0]      scl;
    logic            swp;
    logic [3:0][4:0] bc;
    logic [31:0]     col;
  } slot_t;

  slot_t      m_slot;
  bit         m_loaded = 0;
  bit         m_started = 0;
  int         m_n = 0;
  logic [4:0] e_color = '0;
  bit         e_valid = 0;
  bit         e_take = 0;
  bit         e_busy = 0;
  bit         e_hit = 0;
  bit         bg_now = 0;

  task automatic model_step();
    int w, px, kk, cd;
    logic [4:0] c;
    e_take = 0;
    if (line_start) begin
      m_loaded = 0; e_color = '0; e_valid = 0; e_hit = 0;
    end else if (!m_loaded) begin
      if (pix_en) begin e_color = '0; e_valid = 0; end
      if (sif.slot_valid) begin
        m_slot.pos = sif.pos_x; m_slot.scl = sif.scl_x; m_slot.swp = sif.swp_x; m_slot.col = sif.colors;
        m_slot.bc = {sif.bcolor4, sif.bcolor3, sif.bcolor2, sif.bcolor1};
        m_loaded = 1; m_started = 0; m_n = 0; e_take = 1;
      end
    end else if (pix_en) begin
      w = 16 * (int'(m_slot.scl) + 1);
      if ((!m_started && int'(hpos) == int'(m_slot.pos) && int'(m_slot.pos) < LINE_W) ||
          (m_started && m_n < w)) begin
        px = m_n / (int'(m_slot.scl) + 1);
        kk = m_slot.swp ? 15 - px : px;
        cd = int'((m_slot.col >> (2 * kk)) & 32'd3);
        c  = m_slot.bc[cd];
        e_color = c; e_valid = (c != 0);
        if (c != 0 && bg_now) e_hit = 1;
        m_n++; m_started = 1;
      end else begin
        e_color = '0; e_valid = 0;
      end
    end
    e_busy = m_loaded && (!m_started || m_n < 16 * (int'(m_slot.scl) + 1));
  endtask

  task automatic rand_fields();
    sif.slot_valid = ($urandom % 2) == 0;
    sif.pos_x = 9'($urandom_range(0, 340));
    sif.scl_x = (($urandom % 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
    sif.swp_x = 1'($urandom);
    sif.colors = $urandom;
    sif.bcolor1 = (($urandom % 2) == 0) ? 5'd0 : 5'($urandom);
    sif.bcolor2 = 5'($urandom); sif.bcolor3 = 5'($urandom); sif.bcolor4 = 5'($urandom);
    bg_now = 1'($urandom);
`ifdef SPRITE_HIT_EN
    bg_opaque = bg_now;
`endif
  endtask

  task automatic cyc();
    model_step();
    tick();
    chk("rnd_color", pix_color, e_color);
    chk("rnd_valid", pix_valid, e_valid);
    chk("rnd_busy", busy, e_busy);
    chk("rnd_take", sif.slot_take, e_take);
`ifdef SPRITE_HIT_EN
    chk("rnd_hit", hit, e_hit);
`endif
  endtask

  typedef struct {
    int         h;
    logic [4:0] color;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t tab[20];

  localparam logic [19:0] BC1234 = {5'd4, 5'd3, 5'd2, 5'd1};

  initial begin
    int h, j, lim;
    for (int i = 0; i < 20; i++) begin
      h = 8 + i;
      tab[i].h = h;
      if (h >= 10 && h <= 25) begin
        tab[i].color = 5'((h - 10) % 4 + 1);
        tab[i].valid = 1'b1;
      end else begin
        tab[i].color = 5'd0;
        tab[i].valid = 1'b0;
      end
      tab[i].busy = (h < 25);
    end

    sif.slot_valid = 1'b1;
    sif.pos_x = 9'd10; sif.scl_x = 4'd0; sif.swp_x = 1'b0; sif.colors = 32'hE4E4E4E4;
    sif.bcolor1 = 5'd1; sif.bcolor2 = 5'd2; sif.bcolor3 = 5'd3; sif.bcolor4 = 5'd4;
    #12;
    chk("rst_take", sif.slot_take, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_color", pix_color, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_take", sif.slot_take, 1);
    chk("post_rst_busy", busy, 1);
    chk("post_rst_valid", pix_valid, 0);
    sif.slot_valid = 1'b0;
    tick();
    chk("post_rst_take_single", sif.slot_take, 0);

    load(9'd10, 4'd0, 1'b0, BC1234, 32'hE4E4E4E4);
    for (int i = 0; i < 20; i++) begin
      strobe(tab[i].h);
      chk("tab_color", pix_color, tab[i].color);
      chk("tab_valid", pix_valid, tab[i].valid);
      chk("tab_busy", busy, tab[i].busy);
    end

    // Mirrored and scaled by 3.
    load(9'd10, 4'd2, 1'b1, BC1234, 32'hE4E4E4E4);
    for (h = 8; h <= 60; h++) begin
      strobe(h);
      j = h - 10;
      if (j >= 0 && j < 48) begin
        chk("swp_color", pix_color, 4 - ((j / 3) % 4));
        chk("swp_valid", pix_valid, 1);
      end else begin
        chk("swp_off", pix_valid, 0);
      end
      chk("swp_busy", busy, h < 57);
      if (h == 20) begin
        tick();
        chk("hold_color", pix_color, 4 - ((j / 3) % 4));
      end
    end

    // Fully transparent sprite still walks its 16 strobes.
    load(9'd10, 4'd0, 1'b0, 20'd0, 32'h0);
    for (h = 9; h <= 26; h++) begin
      strobe(h);
      chk("clear_valid", pix_valid, 0);
      chk("clear_busy", busy, h < 25);
    end

    // Truncated by line_start coinciding with the last strobe of the line.
    load(9'd300, 4'd15, 1'b0, BC1234, 32'hE4E4E4E4);
    for (h = 298; h <= 318; h++) strobe(h);
    chk("trunc_318_color", pix_color, 2);
    chk("trunc_318_valid", pix_valid, 1);
    line_start = 1'b1; pix_en = 1'b1; hpos = 9'd319;
    tick();
    line_start = 1'b0; pix_en = 1'b0;
    chk("trunc_color", pix_color, 0);
    chk("trunc_valid", pix_valid, 0);
    chk("trunc_busy", busy, 0);
    tick();
    chk("trunc_idle", busy, 0);

    // Start position beyond the visible line never starts.
    load(9'd330, 4'd0, 1'b0, BC1234, 32'hE4E4E4E4);
    for (h = 325; h <= 340; h++) strobe(h);
    chk("offline_valid", pix_valid, 0);
    chk("offline_busy", busy, 1);

`ifdef SPRITE_HIT_EN
    load(9'd10, 4'd0, 1'b0, BC1234, 32'hE4E4E4E4);
    chk("hit_clear", hit, 0);
    for (h = 8; h <= 20; h++) begin
      bg_opaque = (h == 12);
      strobe(h);
      chk("hit_sticky", hit, h >= 12);
    end
    bg_opaque = 1'b0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("hit_line_clear", hit, 0);
`endif

    for (int ln = 0; ln < 30; ln++) begin
      line_start = 1'b1;
      pix_en = 1'($urandom);
      rand_fields();
      cyc();
      line_start = 1'b0;
      lim = ((ln % 4) == 0) ? int'($urandom_range(0, 340)) : 341;
      h = 0;
      while (h < lim) begin
        pix_en = ($urandom % 4) != 0;
        hpos = 9'(h);
        rand_fields();
        cyc();
        if (pix_en) h++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
